rtl_handshake_arbiter: RTL and testbench

Round-robin arbiter that shares the single `handshake` ready/valid port of the RTL datapath among three requesters, which map onto the `handshake_arr_0..2` channels. Each requester offers an `in1`/`in2` operand pair. A one-entry registered output stage holds the granted request stable until the datapath accepts it. The block sits directly upstream of the RTL instance, and its outputs are the only drivers of that instance's `handshake_valid`, `in1` and `in2`.

---
 rtl/rtl_handshake_arbiter_pkg.sv | 21 ++
 rtl/rtl_handshake_arbiter_rr_pick.sv | 31 +++
 rtl/rtl_handshake_arbiter.sv | 105 ++++++++++
 tb/tb_rtl_handshake_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rtl_handshake_arbiter_pkg.sv
// Shared types, default sizes and helpers for the handshake arbiter and
// any later scheduler that reuses the round-robin picker.
package rtl_arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 3;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_ID_W  = 2;

    typedef logic [DEF_WIDTH-1:0] operand_t;

    // Requester index reached by stepping 'offset' slots past 'base', wrapping at n
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/rtl_handshake_arbiter_rr_pick.sv
// Combinational round-robin priority picker. The search starts one slot
// after last_grant and wraps, so idle requesters never consume a turn.
module rr_pick
    import rtl_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest slot to the nearest so the nearest valid requester is the final assignment
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = ID_W'(rr_index(int'(last_grant), off, N_REQ));
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtl_handshake_arbiter.sv
// Round-robin arbiter sharing one ready/valid downstream port among N_REQ
// requesters. A single registered output stage holds the granted operand
// pair until the datapath takes it, and can reload in the same cycle.
module rtl_handshake_arbiter
    import rtl_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic                        CLK,
    input  logic                        ASYNCRESET,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_in1,
    input  logic [N_REQ-1:0][WIDTH-1:0] req_in2,
    output logic                        handshake_valid,
    input  logic                        handshake_ready,
    output logic [WIDTH-1:0]            in1,
    output logic [WIDTH-1:0]            in2,
    output logic [ID_W-1:0]             grant_id,
    output logic [7:0]                  txn_count
);

    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic            any;
    logic            load_en;
    logic            up_xfer;
    logic            down_xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any        (any)
    );

    // Accept a new pair when the stage is empty or is being drained this cycle; nothing is accepted during reset
    always_comb begin
        load_en   = (state == EMPTY) || handshake_ready;
        up_xfer   = load_en && any && !ASYNCRESET;
        down_xfer = handshake_valid && handshake_ready;
        req_ready = '0;
        if (up_xfer) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Output stage FSM: load on an upstream transfer, empty when drained with nothing new to load
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state           <= EMPTY;
            handshake_valid <= 1'b0;
            in1             <= '0;
            in2             <= '0;
            grant_id        <= '0;
            last_grant      <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                EMPTY: begin
                    if (up_xfer) begin
                        state           <= FULL;
                        handshake_valid <= 1'b1;
                        in1             <= req_in1[winner];
                        in2             <= req_in2[winner];
                        grant_id        <= winner;
                        last_grant      <= winner;
                    end
                end
                FULL: begin
                    if (up_xfer) begin
                        state           <= FULL;
                        handshake_valid <= 1'b1;
                        in1             <= req_in1[winner];
                        in2             <= req_in2[winner];
                        grant_id        <= winner;
                        last_grant      <= winner;
                    end else if (handshake_ready) begin
                        state           <= EMPTY;
                        handshake_valid <= 1'b0;
                    end
                end
                default: begin
                    state           <= EMPTY;
                    handshake_valid <= 1'b0;
                end
            endcase
        end
    end

    // Count completed downstream transfers, wrapping naturally at 8 bits
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            txn_count <= '0;
        end else if (down_xfer) begin
            txn_count <= txn_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_rtl_handshake_arbiter.sv
// Self-checking bench for rtl_handshake_arbiter: directed scenarios plus
// random traffic, all compared against a one-slot behavioural model.
module tb_rtl_handshake_arbiter;

    localparam int N_REQ = 3;
    localparam int WIDTH = 4;
    localparam int ID_W  = 2;

    typedef logic [N_REQ-1:0][WIDTH-1:0] ops_t;

    logic             CLK = 1'b0;
    logic             ASYNCRESET;
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] req_ready;
    ops_t             req_in1;
    ops_t             req_in2;
    logic             handshake_valid;
    logic             handshake_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [ID_W-1:0]  grant_id;
    logic [7:0]       txn_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: one holding slot, last granted index, transfer count
    bit m_full;
    int m_in1;
    int m_in2;
    int m_id;
    int m_last;
    int m_count;

    rtl_handshake_arbiter #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .CLK             (CLK),
        .ASYNCRESET      (ASYNCRESET),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_in1         (req_in1),
        .req_in2         (req_in2),
        .handshake_valid (handshake_valid),
        .handshake_ready (handshake_ready),
        .in1             (in1),
        .in2             (in2),
        .grant_id        (grant_id),
        .txn_count       (txn_count)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        m_full  = 1'b0;
        m_in1   = 0;
        m_in2   = 0;
        m_id    = 0;
        m_last  = N_REQ - 1;
        m_count = 0;
    endfunction

    // First valid requester after the last grant, cyclically; -1 when none
    function automatic int modelWinner(input logic [N_REQ-1:0] v);
        for (int k = 1; k <= N_REQ; k++) begin
            int i;
            i = (m_last + k) % N_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic ops_t randOps();
        ops_t r;
        for (int i = 0; i < N_REQ; i++) r[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        return r;
    endfunction

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_valid"}, int'(handshake_valid), int'(m_full));
        checkOutput({tag, "_in1"}, int'(in1), m_in1);
        checkOutput({tag, "_in2"}, int'(in2), m_in2);
        checkOutput({tag, "_grant"}, int'(grant_id), m_id);
        checkOutput({tag, "_txn"}, int'(txn_count), m_count);
    endtask

    // One clock: drive inputs just after a falling edge, check req_ready, clock, then check held outputs
    task automatic applyStimulus(input logic [N_REQ-1:0] v, input ops_t a, input ops_t b, input logic rdy);
        int w;
        int exp_ready;
        bit up;
        req_valid       = v;
        req_in1         = a;
        req_in2         = b;
        handshake_ready = rdy;
        #1;
        w         = modelWinner(v);
        up        = (w >= 0) && (!m_full || rdy);
        exp_ready = up ? (1 << w) : 0;
        checkOutput("req_ready", int'(req_ready), exp_ready);
        @(posedge CLK);
        if (m_full && rdy) m_count = (m_count + 1) % 256;
        if (up) begin
            m_full = 1'b1;
            m_in1  = int'(a[w]);
            m_in2  = int'(b[w]);
            m_id   = w;
            m_last = w;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        @(negedge CLK);
        checkHeld("held");
    endtask

    task automatic doReset();
        ASYNCRESET      = 1'b1;
        req_valid       = '1;
        handshake_ready = 1'b1;
        #1;
        modelReset();
        checkOutput("reset_req_ready", int'(req_ready), 0);
        checkHeld("reset");
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_hold_req_ready", int'(req_ready), 0);
        ASYNCRESET = 1'b0;
    endtask

    int exp_seq[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        ASYNCRESET      = 1'b0;
        req_valid       = '0;
        req_in1         = '0;
        req_in2         = '0;
        handshake_ready = 1'b0;
        modelReset();
        @(negedge CLK);
        doReset();

        $display("[TB] single request from requester 0");
        applyStimulus(3'b001, {4'd0, 4'd0, 4'd3}, {4'd0, 4'd0, 4'd5}, 1'b1);
        checkOutput("t1_valid", int'(handshake_valid), 1);
        checkOutput("t1_in1", int'(in1), 3);
        checkOutput("t1_in2", int'(in2), 5);
        checkOutput("t1_grant", int'(grant_id), 0);
        applyStimulus(3'b000, '0, '0, 1'b1);
        checkOutput("t1_txn", int'(txn_count), 1);

        $display("[TB] all requesters valid, back-to-back");
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(3'b111, randOps(), randOps(), 1'b1);
            checkOutput("rr_seq", int'(grant_id), exp_seq[k]);
        end
        applyStimulus(3'b000, '0, '0, 1'b1);
        checkOutput("rr_txn6", int'(txn_count), 6);

        $display("[TB] stall with held pair");
        applyStimulus(3'b001, randOps(), randOps(), 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b110, randOps(), randOps(), 1'b0);
            checkOutput("stall_grant", int'(grant_id), 0);
        end
        applyStimulus(3'b110, randOps(), randOps(), 1'b1);
        checkOutput("release_grant", int'(grant_id), 1);

        $display("[TB] skip idle requester");
        applyStimulus(3'b101, randOps(), randOps(), 1'b1);
        checkOutput("skip_grant2", int'(grant_id), 2);
        applyStimulus(3'b101, randOps(), randOps(), 1'b1);
        checkOutput("skip_grant0", int'(grant_id), 0);

        $display("[TB] asynchronous reset while full");
        @(posedge CLK);
        #3;
        ASYNCRESET = 1'b1;
        #1;
        modelReset();
        checkOutput("arst_valid", int'(handshake_valid), 0);
        checkOutput("arst_txn", int'(txn_count), 0);
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        applyStimulus(3'b111, randOps(), randOps(), 1'b1);
        checkOutput("arst_first_grant", int'(grant_id), 0);

        $display("[TB] counter wrap over 256 transfers");
        doReset();
        for (int k = 0; k < 257; k++) begin
            applyStimulus(3'b111, randOps(), randOps(), 1'b1);
        end
        checkOutput("wrap_txn", int'(txn_count), 0);
        checkOutput("wrap_valid", int'(handshake_valid), 1);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(N_REQ'($urandom_range(0, 7)), randOps(), randOps(),
                          1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
